// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine for the pipelined Y86-64 core.
// Takes the M-register fields, runs one data-memory access over a req/ack
// handshake, and returns m_valM / m_stat toward W. Stalls M while busy.
// Optional ack timeout is enabled by defining DMEM_TIMEOUT_EN.
//
// Handshake: dmem_req_o rises together with we/addr/wdata, and all four stay
// stable until the memory returns dmem_ack_i (with rdata/err valid in that
// same cycle). req drops on the edge that samples ack. ack with req low is
// ignored. Only one request is ever outstanding.
module mem_access_unit #(
    parameter int unsigned DMEM_BYTES     = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o,
    output logic        m_stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic [63:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    input  logic        dmem_err_i
);

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state;
    logic [63:0] valm_q;
    logic        err_q;

    logic        is_read;
    logic        is_write;
    logic [63:0] acc_addr;
    logic [64:0] addr_end;
    logic        eligible;
    logic        range_fault;
    logic        start;
    logic        to_hit;

    // Decode the memory operation and pick the address source.
    always_comb begin
        is_read  = (M_icode_i == IMRMOVQ) || (M_icode_i == IPOPQ) || (M_icode_i == IRET);
        is_write = (M_icode_i == IRMMOVQ) || (M_icode_i == IPUSHQ) || (M_icode_i == ICALL);
        acc_addr = ((M_icode_i == IPOPQ) || (M_icode_i == IRET)) ? M_valA_i : M_valE_i;
    end

    // 65-bit end address so addresses near 2^64 cannot wrap into range.
    assign addr_end    = {1'b0, acc_addr} + 65'd8;
    assign range_fault = addr_end > 65'(DMEM_BYTES);
    assign eligible    = (M_stat_i == SAOK) && (is_read || is_write);
    assign start       = eligible && !range_fault;

`ifdef DMEM_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign to_hit = (to_cnt == TIMEOUT_CYCLES - 32'd1);

    // Count ACCESS cycles; held at zero outside ACCESS so every access starts fresh.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            to_cnt <= '0;
        end else if (state == S_ACCESS) begin
            to_cnt <= to_cnt + 32'd1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    logic unused_timeout;

    assign to_hit         = 1'b0;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // Access FSM plus the registered bus outputs and captured response.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            valm_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_ACCESS;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= is_write;
                        dmem_addr_o  <= acc_addr;
                        dmem_wdata_o <= M_valA_i;
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack_i) begin
                        valm_q     <= dmem_we_o ? 64'd0 : dmem_rdata_i;
                        err_q      <= dmem_err_i;
                        dmem_req_o <= 1'b0;
                        state      <= S_DONE;
                    end else if (to_hit) begin
                        valm_q     <= '0;
                        err_q      <= 1'b1;
                        dmem_req_o <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    dmem_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline-facing results: stall while an access is pending, result in DONE.
    always_comb begin
        m_valM_o  = '0;
        m_stat_o  = M_stat_i;
        m_stall_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    m_stall_o = 1'b1;
                end else if (eligible && range_fault) begin
                    m_stat_o = SADR;
                end
            end
            S_ACCESS: begin
                m_stall_o = 1'b1;
            end
            S_DONE: begin
                m_valM_o = valm_q;
                m_stat_o = err_q ? SADR : M_stat_i;
            end
            default: begin
                m_stall_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit. Driver issues
// instructions into M and pushes the expected {stat, valM}; a monitor pops and
// compares whenever M completes (stall low). A memory responder answers with
// programmable wait/err and checks the bus fields against a second queue.
module tb_mem_access_unit;

    localparam int unsigned DMEM = 65536;
`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TB_TO      = 4;
    localparam bit          TIMEOUT_ON = 1'b1;
`else
    localparam int unsigned TB_TO      = 255;
    localparam bit          TIMEOUT_ON = 1'b0;
`endif

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [2:0]  M_stat_i;
    logic [3:0]  M_icode_i;
    logic [63:0] M_valE_i;
    logic [63:0] M_valA_i;
    logic [63:0] m_valM_o;
    logic [2:0]  m_stat_o;
    logic        m_stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic [63:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        dmem_err_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [66:0]  exp_q[$];
    logic [128:0] bus_exp_q[$];
    logic [63:0]  ref_mem [logic [63:0]];
    logic [63:0]  dev_mem [logic [63:0]];

    bit mon_en    = 1'b0;
    bit force_ack = 1'b0;
    int resp_wait = 0;
    bit resp_err  = 1'b0;

    mem_access_unit #(.DMEM_BYTES(DMEM), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .M_stat_i(M_stat_i), .M_icode_i(M_icode_i),
        .M_valE_i(M_valE_i), .M_valA_i(M_valA_i),
        .m_valM_o(m_valM_o), .m_stat_o(m_stat_o), .m_stall_o(m_stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Initial memory content is a fixed function of the address.
    function automatic logic [63:0] fill(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return fill(a);
    endfunction

    function automatic logic [63:0] pick_addr();
        case ($urandom_range(0, 9))
            7:       return 64'(DMEM - 8);
            8:       return 64'(DMEM - 8 + $urandom_range(1, 8));
            9:       return {$urandom, $urandom};
            default: return 64'($urandom_range(0, 63) * 8);
        endcase
    endfunction

    // Reference model + driver: issue one instruction, hold it until M completes.
    task automatic run_op(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] ve,
                          input logic [63:0] va, input int wt, input bit er);
        bit          rd, wr, timed_out, done;
        logic [63:0] a;
        logic [66:0] e;
        int          exp_stall, stalls;
        rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        a  = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
        timed_out = TIMEOUT_ON && (wt >= int'(TB_TO));
        exp_stall = 0;
        if (st != SAOK || !(rd || wr)) begin
            e = {st, 64'd0};
        end else if (a > 64'(DMEM - 8)) begin
            e = {SADR, 64'd0};
        end else begin
            bus_exp_q.push_back({wr, a, va});
            if (timed_out) begin
                exp_stall = 1 + int'(TB_TO);
                e = {SADR, 64'd0};
            end else begin
                exp_stall = wt + 2;
                if (wr) begin
                    e = {(er ? SADR : SAOK), 64'd0};
                    if (!er) ref_mem[a] = va;
                end else begin
                    e = {(er ? SADR : SAOK), ref_rd(a)};
                end
            end
        end
        M_icode_i = ic; M_stat_i = st; M_valE_i = ve; M_valA_i = va;
        resp_wait = wt; resp_err = er;
        exp_q.push_back(e);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_i);
            if (!m_stall_o) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout actual=stalled required=complete icode=%h", ic);
        end
        chk("stall_cycles", 64'(stalls), 64'(exp_stall));
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every completed M cycle must match the head of the expected queue.
    initial begin
        logic [66:0] e;
        forever begin
            @(negedge clk_i);
            if (mon_en && !m_stall_o) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_unexpected actual stat=%0d valM=%h required=none", m_stat_o, m_valM_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_stat_o, m_valM_o} !== e) begin
                        n_bad++;
                        $display("FAIL out_stat_valM actual stat=%0d valM=%h required stat=%0d valM=%h",
                                 m_stat_o, m_valM_o, e[66:64], e[63:0]);
                    end
                end
            end
        end
    end

    // Memory responder: ack after resp_wait cycles of req, stray acks while idle.
    initial begin
        int           wcnt;
        logic [128:0] b;
        wcnt = 0;
        dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            dmem_ack_i   = 1'b0;
            dmem_err_i   = 1'b0;
            dmem_rdata_i = {$urandom, $urandom};
            if (force_ack) begin
                dmem_ack_i = 1'b1;
                dmem_err_i = 1'b1;
                force_ack  = 1'b0;
            end else if (dmem_req_o) begin
                if (wcnt == 0) begin
                    if (bus_exp_q.size() == 0) begin
                        chk("bus_unexpected_req", 64'd1, 64'd0);
                    end else begin
                        b = bus_exp_q.pop_front();
                        chk("bus_we", 64'(dmem_we_o), 64'(b[128]));
                        chk("bus_addr", dmem_addr_o, b[127:64]);
                        if (b[128]) chk("bus_wdata", dmem_wdata_o, b[63:0]);
                    end
                end
                if (wcnt == resp_wait) begin
                    dmem_ack_i = 1'b1;
                    dmem_err_i = resp_err;
                    if (!dmem_we_o) begin
                        dmem_rdata_i = dev_mem.exists(dmem_addr_o) ? dev_mem[dmem_addr_o] : fill(dmem_addr_o);
                    end else if (!resp_err) begin
                        dev_mem[dmem_addr_o] = dmem_wdata_o;
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if ($urandom_range(0, 7) == 0) begin
                    dmem_ack_i = 1'b1;
                    dmem_err_i = 1'b1;
                end
            end
        end
    end

    // Main sequence: reset, directed cases, reset mid-access, long wait, random.
    initial begin
        logic [3:0]  ic;
        logic [2:0]  st;
        logic [63:0] ve, va;
        logic [3:0]  mem_ops[6];
        logic [2:0]  bad_st[4];
        mem_ops = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        bad_st  = '{3'd0, 3'd2, 3'd3, 3'd4};

        rst_n_i = 1'b0;
        M_icode_i = 4'h1; M_stat_i = SAOK; M_valE_i = '0; M_valA_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("rst_req", 64'(dmem_req_o), 64'd0);
        chk("rst_we", 64'(dmem_we_o), 64'd0);
        chk("rst_addr", dmem_addr_o, 64'd0);
        chk("rst_wdata", dmem_wdata_o, 64'd0);
        chk("rst_stall", 64'(m_stall_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        mon_en  = 1'b1;

        dev_mem[64'h100] = 64'hDEADBEEF;
        ref_mem[64'h100] = 64'hDEADBEEF;
        run_op(4'h5, SAOK, 64'h100, 64'h0, 2, 1'b0);
        run_op(4'hA, SAOK, 64'h1F8, 64'h55, 0, 1'b0);
        run_op(4'h4, SAOK, 64'(DMEM - 4), 64'h77, 0, 1'b0);
        run_op(4'h6, SAOK, 64'h1234, 64'h5678, 0, 1'b0);
        run_op(4'h1, SAOK, 64'h0, 64'h0, 0, 1'b0);
        run_op(4'h9, SAOK, 64'h0, 64'h40, 1, 1'b1);
        run_op(4'h5, SAOK, 64'h1F8, 64'h0, 0, 1'b0);
        run_op(4'h5, SAOK, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 1'b0);

        // Reset while an access is outstanding; a late ack must be ignored.
        mon_en = 1'b0;
        bus_exp_q.push_back({1'b0, 64'h300, 64'h0});
        M_icode_i = 4'h5; M_stat_i = SAOK; M_valE_i = 64'h300; M_valA_i = '0;
        resp_wait = 1000;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("rst_mid_req_before", 64'(dmem_req_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        M_icode_i = 4'h1;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        force_ack = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_req_after", 64'(dmem_req_o), 64'd0);
        chk("rst_mid_stall", 64'(m_stall_o), 64'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("late_ack_req", 64'(dmem_req_o), 64'd0);
        chk("late_ack_stall", 64'(m_stall_o), 64'd0);
        chk("late_ack_valM", m_valM_o, 64'd0);
        chk("late_ack_stat", 64'(m_stat_o), 64'(SAOK));
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;

        // Long wait: without a timeout the request simply stays up.
        if (TIMEOUT_ON) run_op(4'h5, SAOK, 64'h200, 64'h0, 1000, 1'b0);
        else            run_op(4'h5, SAOK, 64'h200, 64'h0, 60, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ic = ($urandom_range(0, 1) == 0) ? mem_ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 9) < 7) ? SAOK : bad_st[$urandom_range(0, 3)];
            ve = pick_addr();
            va = ((ic == 4'h9) || (ic == 4'hB)) ? pick_addr() : {$urandom, $urandom};
            run_op(ic, st, ve, va, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        mon_en = 1'b0;
        repeat (2) @(posedge clk_i);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("bus_q_drained", 64'(bus_exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access engine of the pipelined Y86-64 core. It consumes the M-register fields produced at the execute/memory boundary and performs the load or store against data memory over a req/ack handshake. It returns m_valM and the updated m_stat toward the memory/writeback register. While an access is outstanding it raises m_stall_o so pipeline control holds M and upstream stages and bubbles W.

## Interface
Parameters:
- DMEM_BYTES, 65536: data memory size in bytes; valid addresses are 0..DMEM_BYTES-8 for 8-byte accesses.
- TIMEOUT_CYCLES, 255: ack wait limit; used only with DMEM_TIMEOUT_EN.

Ports (clock is clk_i; reset is rst_n_i, synchronous, active-low; one clock domain):
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- M_stat_i  in  3  stat of the instruction in M
- M_icode_i  in  4  icode in M
- M_valE_i  in  64  ALU result / address
- M_valA_i  in  64  store data, or address for popq/ret
- m_valM_o  out  64  loaded value
- m_stat_o  out  3  stat after memory stage
- m_stall_o  out  1  access not yet complete
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  64  byte address
- dmem_wdata_o  out  64  write data
- dmem_rdata_i  in  64  read data, valid with ack
- dmem_ack_i  in  1  access complete
- dmem_err_i  in  1  bus error, valid with ack

## Operation
- Memory ops:
  - Reads: IMRMOVQ (addr = valE), IPOPQ and IRET (addr = valA).
  - Writes: IRMMOVQ, IPUSHQ, ICALL (addr = valE, data = valA).
- An access is eligible only if M_stat_i == SAOK and the icode is a memory op.
- Range check uses 65-bit arithmetic: addr + 8 > DMEM_BYTES is a fault. A fault issues no request and no stall; m_stat_o = SADR, m_valM_o = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Eligible, in-range op: m_stall_o = 1; the next edge goes to ACCESS and registers req = 1, we, addr, wdata.
  - Anything else: pass-through with m_stat_o = M_stat_i (or SADR on a range fault), m_valM_o = 0, m_stall_o = 0.
- ACCESS:
  - m_stall_o = 1.
  - req, we, addr, wdata held stable until ack.
  - On dmem_ack_i: capture rdata (reads; writes capture 0) and err; clear req at that edge; go to DONE.
- DONE:
  - m_stall_o = 0; m_valM_o = captured value.
  - m_stat_o = SADR if err was captured, else M_stat_i.
  - The next edge returns to IDLE (the pipeline advances M on that same edge).
- ack with req = 0 is ignored.
- m_valM_o, m_stat_o, m_stall_o are combinational from state, registers and M inputs. All dmem_* outputs are registered.

## Timing
- Reset (rst_n_i = 0 at an edge): state IDLE; dmem_req_o = 0, dmem_we_o = 0, dmem_addr_o = 0, dmem_wdata_o = 0; captured valM = 0, err = 0; timeout counter = 0.
- Reset during ACCESS drops req at that edge; a late ack is ignored.
- Latency with zero-wait memory: the instruction occupies M for 3 cycles (IDLE stall, ACCESS with ack, DONE). Each extra wait cycle adds one.
- Non-memory ops and faults: 1 cycle, no stall.
- M inputs must be stable while m_stall_o = 1. Pipeline control guarantees this via M_stall.
- Back-to-back memory ops: DONE → IDLE, then the next op stalls in IDLE. There is no overlap of requests.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - A counter runs in ACCESS, cleared on entry.
  - When it reaches TIMEOUT_CYCLES without ack: drop req, capture err = 1, valM = 0, go to DONE (m_stat_o = SADR).
- DMEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for ack.

## Test plan
- MRMOVQ, valE = 0x100, memory returns 0xDEADBEEF with ack after 2 wait cycles → req high 3 cycles at addr 0x100, we = 0; m_stall_o high 4 cycles; DONE shows m_valM_o = 0xDEADBEEF, m_stat_o = SAOK.
- PUSHQ, valE = 0x1F8, valA = 0x55, zero-wait ack → we = 1, wdata = 0x55, addr 0x1F8; stall exactly 2 cycles.
- RMMOVQ, valE = DMEM_BYTES-4 → no req; m_stat_o = SADR, m_stall_o = 0 in the same cycle. OPQ and NOP → pass-through, m_valM_o = 0.
- IRET, valA = 0x40, ack with dmem_err_i = 1 → addr 0x40; DONE shows m_stat_o = SADR. A stray ack while idle leaves state and outputs unchanged.
- Assert rst_n_i low mid-ACCESS → next edge: req = 0, state IDLE; an ack one cycle later is ignored.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack → req drops after 4 ACCESS cycles; DONE with m_stat_o = SADR, m_valM_o = 0. Without the macro, req stays high for 50+ cycles.
